chacha_block_sequencer: RTL and testbench

//  Sequences the ChaCha20 block function for one AEAD message: latches key/nonce/initial counter,

---
 rtl/chacha_block_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_chacha_block_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_block_sequencer.sv
// ChaCha20 block-function sequencer: one AEAD request in, one start per keystream block out.
// Optional POLY_KEYGEN_EN: a counter-0 one-time-key block runs ahead of the keystream.
module chacha_block_sequencer #(
  parameter int unsigned NB_W        = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [255:0]    req_key,
  input  logic [95:0]     req_nonce,
  input  logic [31:0]     req_ctr,
  input  logic [NB_W-1:0] req_nblocks,
  output logic            bf_start,
  output logic [255:0]    bf_key,
  output logic [95:0]     bf_nonce,
  output logic [31:0]     bf_ctr,
  input  logic            bf_done,
  input  logic [511:0]    bf_block,
  output logic            ks_valid,
  input  logic            ks_ready,
  output logic [511:0]    ks_data,
  output logic            ks_last,
`ifdef POLY_KEYGEN_EN
  output logic            otk_valid,
  output logic [255:0]    otk_key,
`endif
  output logic            busy,
  output logic            err_wrap,
  output logic            err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic            init_q;
  logic [255:0]    key_q;
  logic [95:0]     nonce_q;
  logic [31:0]     ctr_q, ctr_d;
  logic [NB_W-1:0] rem_q, rem_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ks_valid_q, ks_valid_d;
  logic [511:0]    ks_data_q;
  logic            bf_start_q;
  logic            err_wrap_q, err_wrap_d;
  logic            err_timeout_q, err_timeout_d;
  logic            accept, wrap, ks_capture, otk_phase;
  logic [32:0]     last_ctr;

  assign accept   = req_valid && req_ready;
  // Last counter the request would use, computed one bit wider to catch the wrap.
  assign last_ctr = {1'b0, req_ctr} + 33'(req_nblocks) - 33'd1;
  assign wrap     = (req_nblocks != '0) && (last_ctr > 33'h0_FFFF_FFFF);

  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    rem_d         = rem_q;
    timer_d       = timer_q;
    ks_valid_d    = ks_valid_q;
    err_wrap_d    = err_wrap_q;
    err_timeout_d = err_timeout_q;
    ks_capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_wrap_d    = wrap;
          err_timeout_d = 1'b0;
          ctr_d         = req_ctr;
          rem_d         = req_nblocks;
          if (!wrap && (req_nblocks != '0)) state_d = StLoad;
        end
      end
      StLoad: state_d = StStart;
      StStart: begin
        state_d = StWait;
        timer_d = '0;
      end
      StWait: begin
        if (bf_done) begin
          if (otk_phase) begin
            state_d = StStart;
          end else begin
            ks_capture = 1'b1;
            ks_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StHold: begin
        if (ks_ready) begin
          ks_valid_d = 1'b0;
          if (rem_q > NB_W'(1)) begin
            ctr_d   = ctr_q + 32'd1;
            rem_d   = rem_q - NB_W'(1);
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      init_q        <= 1'b0;
      key_q         <= '0;
      nonce_q       <= '0;
      ctr_q         <= '0;
      rem_q         <= '0;
      timer_q       <= '0;
      ks_valid_q    <= 1'b0;
      ks_data_q     <= '0;
      bf_start_q    <= 1'b0;
      err_wrap_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_q        <= 1'b1;
      ctr_q         <= ctr_d;
      rem_q         <= rem_d;
      timer_q       <= timer_d;
      ks_valid_q    <= ks_valid_d;
      err_wrap_q    <= err_wrap_d;
      err_timeout_q <= err_timeout_d;
      // Registered so the start pulse comes straight from a flop.
      bf_start_q    <= (state_d == StStart);
      if (accept) begin
        key_q   <= req_key;
        nonce_q <= req_nonce;
      end
      if (ks_capture) ks_data_q <= bf_block;
    end
  end

`ifdef POLY_KEYGEN_EN
  logic         otk_q, otk_valid_q;
  logic [255:0] otk_key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      otk_q       <= 1'b0;
      otk_valid_q <= 1'b0;
      otk_key_q   <= '0;
    end else begin
      otk_valid_q <= 1'b0;
      if (accept) begin
        otk_q <= !wrap && (req_nblocks != '0);
      end else if ((state_q == StWait) && bf_done && otk_q) begin
        otk_q       <= 1'b0;
        otk_valid_q <= 1'b1;
        otk_key_q   <= bf_block[255:0];
      end
    end
  end

  assign otk_phase = otk_q;
  assign otk_valid = otk_valid_q;
  assign otk_key   = otk_key_q;
`else
  assign otk_phase = 1'b0;
`endif

  assign req_ready   = init_q && (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign bf_start    = bf_start_q;
  assign bf_key      = key_q;
  assign bf_nonce    = nonce_q;
  assign bf_ctr      = otk_phase ? 32'd0 : ctr_q;
  assign ks_valid    = ks_valid_q;
  assign ks_data     = ks_data_q;
  assign ks_last     = ks_valid_q && (rem_q == NB_W'(1));
  assign err_wrap    = err_wrap_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Bench for chacha_block_sequencer: plays block function and serializer against an
// event-scheduled protocol model; honours POLY_KEYGEN_EN when defined.
module tb_chacha_block_sequencer;
  localparam int unsigned NB_W = 16;
  localparam int unsigned TO   = 64;
`ifdef POLY_KEYGEN_EN
  localparam int POLY = 1;
`else
  localparam int POLY = 0;
`endif

  logic            clk, rst_n;
  logic            req_valid, req_ready;
  logic [255:0]    req_key;
  logic [95:0]     req_nonce;
  logic [31:0]     req_ctr;
  logic [NB_W-1:0] req_nblocks;
  logic            bf_start, bf_done;
  logic [255:0]    bf_key;
  logic [95:0]     bf_nonce;
  logic [31:0]     bf_ctr;
  logic [511:0]    bf_block, ks_data;
  logic            ks_valid, ks_ready, ks_last;
  logic            busy, err_wrap, err_timeout;
`ifdef POLY_KEYGEN_EN
  logic            otk_valid;
  logic [255:0]    otk_key;
`endif

  chacha_block_sequencer #(.NB_W(NB_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_nonce(req_nonce), .req_ctr(req_ctr), .req_nblocks(req_nblocks),
    .bf_start(bf_start), .bf_key(bf_key), .bf_nonce(bf_nonce), .bf_ctr(bf_ctr),
    .bf_done(bf_done), .bf_block(bf_block),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_last(ks_last),
`ifdef POLY_KEYGEN_EN
    .otk_valid(otk_valid), .otk_key(otk_key),
`endif
    .busy(busy), .err_wrap(err_wrap), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_errors;
  int cyc;

  // Model: expected outputs for the current cycle plus scheduled protocol events.
  bit           m_init, e_ready, active, inflight, hold, hold_last, otk_pending;
  bit           e_err_wrap, e_err_to, e_otk_valid;
  logic [255:0] e_otk_key, m_key;
  logic [95:0]  m_nonce;
  logic [511:0] hold_data;
  int           start_at, start_cyc, done_at, blocks_left;
  int unsigned  cur_ctr;
  int unsigned  ctr_q[$];

  // Stimulus controls and observation logs.
  bit              pend_req, withhold;
  int              ks_mode, done_delay, hold_age;
  logic [255:0]    p_key;
  logic [95:0]     p_nonce;
  logic [31:0]     p_ctr;
  logic [NB_W-1:0] p_nb;
  int unsigned     start_log[$];
  int              first_start, acc_cyc, n_last_hs, otk_pulses;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_init = 0; e_ready = 0; active = 0; inflight = 0; hold = 0; hold_last = 0;
    otk_pending = 0; e_err_wrap = 0; e_err_to = 0; e_otk_valid = 0;
    start_at = -1; done_at = -1; blocks_left = 0; pend_req = 0; hold_age = 0;
    ctr_q.delete();
  endtask

  task automatic schedule(input int t);
    start_at = t;
    cur_ctr  = ctr_q.pop_front();
  endtask

  // Compare this cycle, drive inputs for the next edge, advance the model one cycle.
  task automatic step();
    logic [511:0] blk;
    bit done_now, hs;
    chk("req_ready", req_ready, e_ready);
    chk("busy", busy, active);
    chk("bf_start", bf_start, cyc == start_at);
    chk("ks_valid", ks_valid, hold);
    chk("err_wrap", err_wrap, e_err_wrap);
    chk("err_timeout", err_timeout, e_err_to);
`ifdef POLY_KEYGEN_EN
    chk("otk_valid", otk_valid, e_otk_valid);
    if (e_otk_valid) chk("otk_key", otk_key, e_otk_key);
    if (otk_valid) otk_pulses++;
`endif
    if (hold) begin
      chk("ks_data", ks_data, hold_data);
      chk("ks_last", ks_last, hold_last);
    end
    if (cyc == start_at || inflight) begin
      chk("bf_ctr", bf_ctr, cur_ctr);
      chk("bf_key", bf_key, m_key);
      chk("bf_nonce", bf_nonce, m_nonce);
    end
    if (bf_start) begin
      start_log.push_back(bf_ctr);
      if (first_start < 0) first_start = cyc;
    end

    blk      = rand512();
    done_now = inflight && (cyc == done_at);
    bf_done  = done_now || (!inflight && $urandom_range(0, 7) == 0);
    bf_block = blk;
    hold_age = hold ? hold_age + 1 : 0;
    case (ks_mode)
      0:       ks_ready = 1'b1;
      1:       ks_ready = 1'($urandom_range(0, 1));
      default: ks_ready = (hold_age > 20);
    endcase
    if (pend_req) begin
      req_valid = 1; req_key = p_key; req_nonce = p_nonce; req_ctr = p_ctr; req_nblocks = p_nb;
    end else if (active && $urandom_range(0, 3) == 0) begin
      blk = rand512();
      req_valid = 1; req_key = blk[255:0]; req_nonce = blk[351:256];
      req_ctr = blk[383:352]; req_nblocks = blk[399:384];
    end else begin
      req_valid = 0;
    end
    if (ks_valid && ks_ready && ks_last) n_last_hs++;

    hs = hold && ks_ready;
    e_otk_valid = 0;
    if (cyc == start_at) begin
      inflight = 1; start_cyc = cyc; start_at = -1;
      done_at = withhold ? -1 : cyc + (done_delay > 0 ? done_delay : $urandom_range(1, 12));
    end
    if (e_ready && req_valid) begin
      acc_cyc = cyc; pend_req = 0; e_err_wrap = 0; e_err_to = 0;
      m_key = req_key; m_nonce = req_nonce;
      if (req_nblocks != 0) begin
        if (longint'(req_ctr) + longint'(req_nblocks) - 1 > 64'hFFFF_FFFF) begin
          e_err_wrap = 1;
        end else begin
          active = 1; blocks_left = int'(req_nblocks); otk_pending = (POLY != 0);
          ctr_q.delete();
          if (POLY != 0) ctr_q.push_back(0);
          for (int i = 0; i < int'(req_nblocks); i++) ctr_q.push_back(req_ctr + i);
          schedule(cyc + 2);
        end
      end
    end else if (done_now) begin
      inflight = 0;
      if (otk_pending) begin
        otk_pending = 0; e_otk_valid = 1; e_otk_key = bf_block[255:0];
        schedule(cyc + 1);
      end else begin
        hold = 1; hold_data = bf_block; hold_last = (blocks_left == 1);
      end
    end else if (inflight && cyc == start_cyc + int'(TO)) begin
      inflight = 0; active = 0; e_err_to = 1;
    end else if (hs) begin
      hold = 0; blocks_left--;
      if (blocks_left > 0) schedule(cyc + 1);
      else active = 0;
    end
    if (rst_n) m_init = 1;
    e_ready = m_init && !active;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_req(input logic [31:0] ctr, input int nb);
    logic [511:0] r;
    start_log.delete(); n_last_hs = 0; otk_pulses = 0; first_start = -1; acc_cyc = -1;
    r = rand512();
    p_key = r[255:0]; p_nonce = r[351:256]; p_ctr = ctr; p_nb = NB_W'(nb); pend_req = 1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (!pend_req && !active) break;
    end
    chk("request_completes", {31'd0, pend_req || active}, 0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    rst_n = 0; req_valid = 0; req_key = '0; req_nonce = '0; req_ctr = '0; req_nblocks = '0;
    bf_done = 0; bf_block = '0; ks_ready = 0;
    withhold = 0; ks_mode = 0; done_delay = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    step();
    chk("ready_after_reset", req_ready, 1);

    // Three blocks from counter 1, fixed block-function latency, serializer always ready.
    ks_mode = 0; done_delay = 10;
    run_req(32'd1, 3);
    chk("t2_nstarts", start_log.size(), 3 + POLY);
    chk("t2_ctr0", start_log[POLY], 32'd1);
    chk("t2_ctr1", start_log[POLY + 1], 32'd2);
    chk("t2_ctr2", start_log[POLY + 2], 32'd3);
    chk("t2_accept_to_start", first_start - acc_cyc, 2);
    chk("t2_last_count", n_last_hs, 1);

    // Serializer stalls 20 cycles per block.
    ks_mode = 2;
    run_req(32'h10, 2);
    chk("t3_nstarts", start_log.size(), 2 + POLY);

    // Counter ceiling: reaching FFFFFFFF is legal, going past is not.
    ks_mode = 1; done_delay = 0;
    run_req(32'hFFFF_FFFE, 2);
    chk("t4_last_ctr", start_log[start_log.size() - 1], 32'hFFFF_FFFF);
    chk("t4_no_wrap", err_wrap, 0);
    run_req(32'hFFFF_FFFE, 3);
    chk("t4_wrap_nstarts", start_log.size(), 0);
    chk("t4_wrap_flag", err_wrap, 1);
    run_req(32'd5, 0);
    chk("t4_zero_nstarts", start_log.size(), 0);
    chk("t4_zero_clears_wrap", err_wrap, 0);

    // Block function never answers, then a normal request clears the error.
    withhold = 1;
    run_req(32'd9, 2);
    chk("t5_timeout_flag", err_timeout, 1);
    chk("t5_timeout_nstarts", start_log.size(), 1);
    withhold = 0;
    run_req(32'd20, 1);
    chk("t5_timeout_cleared", err_timeout, 0);
    chk("t5_recover_nstarts", start_log.size(), 1 + POLY);

    // Latest acceptable bf_done.
    done_delay = TO;
    run_req(32'd3, 1);
    chk("late_done_no_timeout", err_timeout, 0);
    done_delay = 0;

    // Reset while waiting on the block function.
    withhold = 1;
    r_t1: begin
      logic [511:0] r;
      r = rand512();
      p_key = r[255:0]; p_nonce = r[351:256]; p_ctr = 32'd7; p_nb = 3; pend_req = 1;
      for (int i = 0; i < 100; i++) begin
        step();
        if (inflight && cyc >= start_cyc + 5) break;
      end
    end
    chk("t1_busy_before_reset", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("t1_rst_req_ready", req_ready, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_bf_start", bf_start, 0);
    chk("t1_rst_bf_ctr", bf_ctr, 0);
    chk("t1_rst_bf_key", bf_key, 0);
    chk("t1_rst_bf_nonce", bf_nonce, 0);
    chk("t1_rst_ks_valid", ks_valid, 0);
    chk("t1_rst_ks_last", ks_last, 0);
    chk("t1_rst_ks_data", ks_data, 0);
    chk("t1_rst_err_wrap", err_wrap, 0);
    chk("t1_rst_err_timeout", err_timeout, 0);
    req_valid = 0; bf_done = 0; ks_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; cyc += 2;
    model_reset(); withhold = 0;
    step();
    chk("t1_ready_after_release", req_ready, 1);

    // Randomized requests, some near the counter ceiling.
    repeat (25) begin
      ks_mode = $urandom_range(0, 1);
      run_req(($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 5) : $urandom,
              $urandom_range(0, 5));
    end

`ifdef POLY_KEYGEN_EN
    ks_mode = 0;
    run_req(32'd1, 1);
    chk("t6_otk_pulses", otk_pulses, 1);
    chk("t6_first_ctr", start_log[0], 32'd0);
    chk("t6_second_ctr", start_log[1], 32'd1);
    chk("t6_last_count", n_last_hs, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
